ntt_stage_controller: RTL

Sequencer that drives radix_2 through a complete in-place N-point NTT or INTT held in a dual-port coefficient RAM.
- Generates, one butterfly per cycle, the RAM read address pair, twiddle ROM address pair and butterfly select.
- Delays each address pair by the read-plus-butterfly pipeline depth to produce the write-back pair.
- Drains the pipeline between stages so no stage reads a word the previous stage has not yet written.

---
 rtl/ntt_stage_controller.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ntt_stage_controller.sv
// ntt_stage_controller
//
// Sequences one complete in-place N-point NTT or INTT over a dual-port
// coefficient RAM. Each cycle in RUN it issues one butterfly: the RAM read
// address pair, the twiddle ROM address pair and the radix_2 select. The read
// address pair, together with its strobe, goes through a D-deep shift register
// (D = 1 + BF_LATENCY, covering one cycle of RAM read latency plus the
// butterfly pipe). That delayed copy becomes the write-back strobe and
// addresses. After every stage the sequencer drains for D cycles. As a result,
// the next stage never reads a word whose update is still in flight.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start, mode          transform request and direction (0 NTT, 1 INTT);
//                        both are sampled only in IDLE
//   busy, done           busy covers RUN+DRAIN; done pulses for one cycle in FIN
//   rd_en, rd_addr_1/2   RAM read strobe and operand address pair
//   tw_addr_1/2          twiddle ROM addresses (tw_addr_1 is always the unity entry)
//   bf_select            radix_2 select; equals the latched mode while busy
//   wr_en, wr_addr_1/2   RAM write strobe and addresses (the reads, delayed by D)
//   stage                current stage index
//   fsm_state            controller state, exposed for debug
//
// Handshake: there is no back-pressure. A start seen at a clock edge while in
// IDLE is accepted unconditionally. A start seen in any other state is ignored.
// Every output is decoded from registers only.
module ntt_stage_controller #(
  parameter int width      = 16,
  parameter int N          = 256,
  parameter int LOG_N      = 8,
  parameter int BF_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_1,
  output logic [LOG_N-1:0] rd_addr_2,
  output logic [LOG_N-2:0] tw_addr_1,
  output logic [LOG_N-2:0] tw_addr_2,
  output logic             bf_select,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_1,
  output logic [LOG_N-1:0] wr_addr_2,
  output logic [LOG_N-1:0] stage,
  output logic [1:0]       fsm_state
);

  localparam int D    = 1 + BF_LATENCY;
  localparam int HALF = N / 2;
  localparam int CW   = (D > 1) ? $clog2(D) : 1;

  generate
    if ((N != (1 << LOG_N)) || (LOG_N < 2) || (width < 1) || (BF_LATENCY < 0)) begin : g_bad_param
      $error("ntt_stage_controller: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LOG_N-1:0] s_q, s_d;
  logic [LOG_N-2:0] k_q, k_d;
  logic [CW-1:0]    dc_q, dc_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      s_q     <= '0;
      k_q     <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dc_q    <= dc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    s_d     = s_q;
    k_d     = k_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          s_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == (LOG_N-1)'(HALF - 1)) begin
          state_d = S_DRAIN;
          dc_d    = '0;
        end else begin
          k_d = k_q + (LOG_N-1)'(1);
        end
      end
      S_DRAIN: begin
        // The final DRAIN cycle is the cycle in which the stage's last write lands.
        if (dc_q == CW'(D - 1)) begin
          if (s_q == LOG_N'(LOG_N - 1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + LOG_N'(1);
            k_d     = '0;
          end
        end else begin
          dc_d = dc_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generation. span is a power of two 2^sh. Therefore j = k mod span is
  // a mask, and g*2*span = (k with the low sh bits cleared) << 1.
  // ---------------------------------------------------------------------------
  logic             rd_active;
  logic [LOG_N-1:0] kx, sh, ts, span, mask, j, a1, a2;
  logic [LOG_N-2:0] tw2;

  always_comb begin
    kx   = {1'b0, k_q};
    sh   = mode_q ? s_q : (LOG_N'(LOG_N - 1) - s_q);
    ts   = mode_q ? (LOG_N'(LOG_N - 1) - s_q) : s_q;
    span = LOG_N'(1) << sh;
    mask = span - LOG_N'(1);
    j    = kx & mask;
    a1   = ((kx & ~mask) << 1) | j;
    a2   = a1 | span;                // bit sh of a1 is always clear
    tw2  = (LOG_N-1)'(j << ts);
  end

  assign rd_active = (state_q == S_RUN);

  // ---------------------------------------------------------------------------
  // Write-back pipe: a read issued in cycle c appears as a write in cycle c+D
  // ---------------------------------------------------------------------------
  logic [D-1:0]            pv_q;
  logic [D-1:0][LOG_N-1:0] pa1_q, pa2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q  <= '0;
      pa1_q <= '0;
      pa2_q <= '0;
    end else begin
      pv_q[0]  <= rd_active;
      pa1_q[0] <= rd_addr_1;
      pa2_q[0] <= rd_addr_2;
      for (int i = 1; i < D; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pa1_q[i] <= pa1_q[i-1];
        pa2_q[i] <= pa2_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Addresses are forced to zero when no access is in progress.
  // ---------------------------------------------------------------------------
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign rd_en     = rd_active;
  assign rd_addr_1 = rd_active ? a1 : '0;
  assign rd_addr_2 = rd_active ? a2 : '0;
  assign tw_addr_1 = '0;
  assign tw_addr_2 = rd_active ? tw2 : '0;
  assign bf_select = busy & mode_q;
  assign wr_en     = pv_q[D-1];
  assign wr_addr_1 = pa1_q[D-1];
  assign wr_addr_2 = pa2_q[D-1];
  assign stage     = s_q;
  assign fsm_state = state_q;

endmodule
